clk_div_ratio_scheduler: RTL and testbench
==========================================

// Module: clk_div_ratio_scheduler
// PURPOSE
//  Shares one integer clock divider between NUM_REQ requesters that change its divide ratio.
//  Round-robin arbitration; each granted change runs a glitch-safe sequence:
//  gate divider enable, load ratio, re-enable, wait lock, acknowledge.
//  Sits beside the divider; drives its i_div_ratio and i_clk_en from the i_ref_clk domain.
// PARAMETERS
//  DIV_RATIO_WIDTH  8   width of divide ratio (matches divider)
//  NUM_REQ          2   number of requesters, >=2
//  SETTLE_CYCLES    4   cycles enable held low before ratio load, >=1
//  LOCK_CYCLES      8   cycles after re-enable before ack, >=1
//  RESET_RATIO      2   ratio driven out of reset, >=2
// PORTS
//  i_ref_clk    in   1                      reference clock, all logic on rising edge
//  i_rst_n      in   1                      reset, synchronous, active-low
//  i_en_req     in   1                      global divider enable request
//  i_req_valid  in   NUM_REQ                per-requester change request
//  i_req_ratio  in   NUM_REQ*DIV_RATIO_WIDTH  requested ratios, req k at [k*W +: W]
//  o_req_ready  out  NUM_REQ                one-hot 1-cycle completion pulse
//  o_req_err    out  1                      1-cycle reject pulse, coincident with o_req_ready
//  o_div_ratio  out  DIV_RATIO_WIDTH        ratio to divider
//  o_clk_en     out  1                      enable to divider
//  o_busy       out  1                      high in every state except IDLE
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge): state IDLE, o_div_ratio=RESET_RATIO, o_clk_en=0, o_req_ready=0,
//   o_req_err=0, o_busy=0, RR pointer=0. Reset mid-sequence aborts it: no ready pulse issued.
//  All outputs registered. States IDLE, DRAIN, LOAD, LOCK, ACK.
//  IDLE: o_clk_en <= i_en_req. If any valid: grant first valid at/after RR pointer, latch its
//   index and ratio (cycle 0); RR pointer <= granted+1 (mod NUM_REQ) on grant.
//   - ratio < 2: -> ACK, o_req_err=1, ratio and enable untouched.
//   - ratio == o_div_ratio: -> ACK, no enable drop, o_req_err=0.
//   - else -> DRAIN.
//  DRAIN: o_clk_en=0 for cycles 1..SETTLE_CYCLES, then -> LOAD.
//  LOAD: o_div_ratio holds new ratio from cycle SETTLE_CYCLES+1; o_clk_en still 0. 1 cycle -> LOCK.
//  LOCK: cycles SETTLE_CYCLES+2 .. SETTLE_CYCLES+LOCK_CYCLES+1; o_clk_en <= i_en_req. -> ACK.
//  ACK: o_req_ready[grant]=1 for exactly 1 cycle (cycle S+L+2 on full path, cycle 1 on fast
//   paths); -> IDLE. No new grant in ACK cycle; earliest next grant is the following IDLE.
//  o_div_ratio changes only while o_clk_en=0 (except reset).
//  Requester holds valid and ratio until its ready pulse. Valid still high the cycle after ready
//   is a new request. Valid dropped mid-sequence: sequence completes, ready still pulses.
//  Ratio changes on non-granted inputs during a sequence are ignored until their grant.
//  i_en_req=0 in IDLE/LOCK forces o_clk_en=0 next cycle; sequencing otherwise unaffected.
// CONFIGURATION
//  CLK_DIV_SCHED_RATIO_CLAMP_EN defined: requested ratio <2 clamped to 2, never rejected;
//   o_req_err tied 0; clamped value then follows normal equal/different path.
//  Not defined: ratio <2 rejected as above with o_req_err pulse.
// TESTING  (defaults S=4, L=8; cycle 0 = IDLE grant cycle)
//  Reset 3 cycles low -> o_div_ratio=2, o_clk_en=0, o_req_ready=0, o_busy=0.
//  i_en_req=1, req0 ratio=5 -> o_clk_en 0 cycles 1-5, o_div_ratio=5 from cycle 5,
//   o_clk_en=1 from cycle 6, o_req_ready=01 at cycle 14 only, o_busy=1 cycles 1-14.
//  req0=3, req1=7 both valid at cycle 0 -> ready[0] cycle 14, req1 granted cycle 15,
//   ready[1] cycle 29, final o_div_ratio=7.
//  req0 ratio=1, macro off -> ready[0] and o_req_err at cycle 1, o_clk_en stays 1, ratio unchanged;
//   macro on -> o_req_err=0, ratio 2 (equal current) -> ready at cycle 1.
//  Current ratio 4, req1 ratio=4 -> ready[1] at cycle 1, o_clk_en never drops.
//  Reset asserted in LOCK -> next cycle IDLE, o_div_ratio=2, o_clk_en=0, no ready pulse.

Source files
------------

// File: rtl/clk_div_ratio_scheduler.sv
// Round-robin scheduler that sequences glitch-safe ratio changes on one shared clock divider.
// Optional macro CLK_DIV_SCHED_RATIO_CLAMP_EN: clamp ratios below 2 up to 2 instead of rejecting them.
module clk_div_ratio_scheduler #(
  parameter int DIV_RATIO_WIDTH = 8,
  parameter int NUM_REQ         = 2,
  parameter int SETTLE_CYCLES   = 4,
  parameter int LOCK_CYCLES     = 8,
  parameter int RESET_RATIO     = 2
) (
  input  logic                               i_ref_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en_req,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*DIV_RATIO_WIDTH-1:0] i_req_ratio,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic                               o_req_err,
  output logic [DIV_RATIO_WIDTH-1:0]         o_div_ratio,
  output logic                               o_clk_en,
  output logic                               o_busy
);
  localparam int W     = DIV_RATIO_WIDTH;
  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CMAX  = (SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES;
  localparam int CW    = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, LOCK, ACK} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [W-1:0]         ratio_q, ratio_d;
  logic [W-1:0]         div_q, div_d;
  logic                 en_q, en_d;
  logic [NUM_REQ-1:0]   rdy_q, rdy_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 gnt_found;
  logic [IW-1:0]        gnt_idx;
  logic [W-1:0]         sel_ratio;
  logic [W-1:0]         eff_ratio;
  logic                 bad_ratio;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int k;
    k         = 0;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!gnt_found && i_req_valid[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end

  always_comb begin
    sel_ratio = i_req_ratio[int'(gnt_idx)*W +: W];
`ifdef CLK_DIV_SCHED_RATIO_CLAMP_EN
    eff_ratio = (sel_ratio < W'(2)) ? W'(2) : sel_ratio;
    bad_ratio = 1'b0;
`else
    eff_ratio = sel_ratio;
    bad_ratio = (sel_ratio < W'(2));
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ratio_d = ratio_q;
    div_d   = div_q;
    en_d    = en_q;
    rdy_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = i_en_req;
        if (gnt_found) begin
          gnt_d   = gnt_idx;
          ratio_d = eff_ratio;
          ptr_d   = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + IW'(1);
          if (bad_ratio) begin
            state_d = ACK;
            rdy_d   = NUM_REQ'(1) << gnt_idx;
            err_d   = 1'b1;
          end else if (eff_ratio == div_q) begin
            state_d = ACK;
            rdy_d   = NUM_REQ'(1) << gnt_idx;
          end else begin
            state_d = DRAIN;
            cnt_d   = '0;
            en_d    = 1'b0;
          end
        end
      end
      DRAIN: begin
        en_d = 1'b0;
        if (cnt_q == CW'(SETTLE_CYCLES-1)) begin
          state_d = LOAD;
          div_d   = ratio_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD: begin
        state_d = LOCK;
        cnt_d   = '0;
        en_d    = i_en_req;
      end
      LOCK: begin
        en_d = i_en_req;
        if (cnt_q == CW'(LOCK_CYCLES-1)) begin
          state_d = ACK;
          rdy_d   = NUM_REQ'(1) << gnt_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ratio_q <= W'(RESET_RATIO);
      div_q   <= W'(RESET_RATIO);
      en_q    <= 1'b0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ratio_q <= ratio_d;
      div_q   <= div_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_req_ready = rdy_q;
  assign o_req_err   = err_q;
  assign o_div_ratio = div_q;
  assign o_clk_en    = en_q;
  assign o_busy      = busy_q;
endmodule

// File: tb/tb_clk_div_ratio_scheduler.sv
// Scoreboard bench: stimulus queues expected completions, a negedge monitor pops and compares them.
module tb_clk_div_ratio_scheduler;
  localparam int W = 8;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en_req;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_ratio;
  logic [N-1:0]     req_ready;
  logic             req_err;
  logic [W-1:0]     div_ratio;
  logic             clk_en;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [N-1:0] rdy;
    logic         err;
    logic [W-1:0] ratio;
    int           at;
  } exp_t;
  exp_t sb[$];

  clk_div_ratio_scheduler #(
    .DIV_RATIO_WIDTH(W), .NUM_REQ(N), .SETTLE_CYCLES(4), .LOCK_CYCLES(8), .RESET_RATIO(2)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_en_req   (en_req),
    .i_req_valid(req_valid),
    .i_req_ratio(req_ratio),
    .o_req_ready(req_ready),
    .o_req_err  (req_err),
    .o_div_ratio(div_ratio),
    .o_clk_en   (clk_en),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if ((|req_ready) === 1'b1 || req_err === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: ready=%b err=%b cycle %0d", req_ready, req_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (req_ready !== e.rdy || req_err !== e.err || div_ratio !== e.ratio || cyc != e.at) begin
          errors++;
          $display("FAIL completion: got ready=%b err=%b ratio=%0d cycle=%0d expected ready=%b err=%b ratio=%0d cycle=%0d",
                   req_ready, req_err, div_ratio, cyc, e.rdy, e.err, e.ratio, e.at);
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [W-1:0] r);
    req_valid[idx]       = 1'b1;
    req_ratio[idx*W +: W] = r;
  endtask

  task automatic expect_done(input logic [N-1:0] rdy, input logic err, input logic [W-1:0] r, input int at);
    exp_t e;
    e.rdy = rdy; e.err = err; e.ratio = r; e.at = at;
    sb.push_back(e);
  endtask

  // Wait (bounded) until all valids are withdrawn, dropping each on its ready pulse.
  task automatic drain_reqs(input int budget);
    int n;
    n = 0;
    while (req_valid != '0 && n < budget) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ready;
      n++;
    end
    if (req_valid != '0) begin
      checks++; errors++;
      $display("FAIL timeout: valid=%b still pending at cycle %0d", req_valid, cyc);
      req_valid = '0;
    end
  endtask

  initial begin
    int c;
    logic exp_err;
`ifdef CLK_DIV_SCHED_RATIO_CLAMP_EN
    exp_err = 1'b0;
`else
    exp_err = 1'b1;
`endif
    rst_n = 1'b0; en_req = 1'b0; req_valid = '0; req_ratio = '0;
    repeat (3) @(negedge clk);
    chk("rst_ratio", 32'(div_ratio), 2);
    chk("rst_en",    32'(clk_en), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1; en_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_en", 32'(clk_en), 1);

    // Ratio 1: rejected (or clamped to the current 2), fast path either way.
    c = cyc; issue(0, 8'd1); expect_done(2'b01, exp_err, 8'd2, c + 1);
    drain_reqs(20);
    chk("low_en_kept", 32'(clk_en), 1);
    chk("low_ratio_kept", 32'(div_ratio), 2);

    // Full sequence to ratio 5 with per-cycle enable/ratio/busy checks.
    @(negedge clk);
    c = cyc; issue(0, 8'd5); expect_done(2'b01, 1'b0, 8'd5, c + 14);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("seq_en_c%0d", k),    32'(clk_en),    (k >= 1 && k <= 5) ? 0 : 1);
      chk($sformatf("seq_ratio_c%0d", k), 32'(div_ratio), (k >= 5) ? 5 : 2);
      chk($sformatf("seq_busy_c%0d", k),  32'(busy),      (k <= 14) ? 1 : 0);
      req_valid = req_valid & ~req_ready;
    end
    chk("seq_valid_dropped", 32'(req_valid), 0);

    // req1 to ratio 4 (full), then req1 ratio 4 again (equal, enable never drops).
    c = cyc; issue(1, 8'd4); expect_done(2'b10, 1'b0, 8'd4, c + 14);
    drain_reqs(40);
    @(negedge clk);
    c = cyc; issue(1, 8'd4); expect_done(2'b10, 1'b0, 8'd4, c + 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("eq_en_c%0d", k), 32'(clk_en), 1);
      req_valid = req_valid & ~req_ready;
    end

    // Both requesters at once: round-robin pointer is back at 0.
    @(negedge clk);
    c = cyc; issue(0, 8'd3); issue(1, 8'd7);
    expect_done(2'b01, 1'b0, 8'd3, c + 14);
    expect_done(2'b10, 1'b0, 8'd7, c + 29);
    drain_reqs(60);
    chk("rr_final_ratio", 32'(div_ratio), 7);

    // Enable request drop while idle.
    @(negedge clk);
    en_req = 1'b0;
    @(negedge clk);
    chk("en_drop", 32'(clk_en), 0);
    en_req = 1'b1;
    @(negedge clk);
    chk("en_restore", 32'(clk_en), 1);

    // Reset during LOCK aborts the sequence with no ready pulse.
    c = cyc; issue(0, 8'd9);
    repeat (8) @(negedge clk);
    chk("lock_en_before_rst", 32'(clk_en), 1);
    chk("lock_ratio_before_rst", 32'(div_ratio), 9);
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("abort_ratio", 32'(div_ratio), 2);
    chk("abort_en",    32'(clk_en), 0);
    chk("abort_busy",  32'(busy), 0);
    chk("abort_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
